i2c_master_wr: RTL and testbench

I2C_MASTER_WR -- requirements
Module: i2c_master_wr

---
 rtl/i2c_master_wr.sv | 173 +++++++++++++++++
 tb/tb_i2c_master_wr.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_master_wr.sv
// i2c_master_wr: write-only I2C master. Sends {addr, W} followed by up to
// MAX_BYTES payload bytes, then STOP. Each START/HOLD/STOP phase lasts four
// ticks; each bit lasts four ticks (BIT_I..BIT_IV).
// Optional feature: define I2C_ACK_CHECK_EN to sample the slave ACK and abort
// the frame on NACK. Without it the bus is never read and o_nack stays 0.
module i2c_master_wr #(
    parameter int MAX_BYTES = 4,
    localparam int LEN_W = $clog2(MAX_BYTES + 1)
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_div_clk,
    input  logic                   i_start,
    input  logic [6:0]             i_addr,
    input  logic [LEN_W-1:0]       i_len,
    input  logic [8*MAX_BYTES-1:0] i_data,
    output logic                   o_ready,
    output logic                   o_done,
    output logic                   o_nack,
    output logic                   o_scl,
    inout  wire                    io_sda
);

    typedef enum logic [3:0] {
        StIdle,
        StStartI,
        StStartII,
        StHoldI,
        StBitI,
        StBitII,
        StBitIII,
        StBitIV,
        StHoldII,
        StStopI,
        StStopII
    } state_e;

    state_e                 r_state;
    logic [1:0]             r_qcnt;   // tick count inside a four-tick phase
    logic [3:0]             r_bit;    // 0..7 data bits, 8 = ACK bit
    logic [LEN_W-1:0]       r_byte;   // 0 = address byte, k = payload byte k-1
    logic [LEN_W-1:0]       r_len;
    logic [6:0]             r_addr;
    logic [8*MAX_BYTES-1:0] r_data;   // current payload byte kept in the top 8 bits
    logic                   r_ready;
    logic                   r_done;
    logic                   r_nack;
    logic                   r_scl;
    logic                   r_sda;

    logic [7:0]             w_cur_byte;
    logic                   w_scl;
    logic                   w_sda;
    logic                   w_last_byte;

    assign w_cur_byte  = (r_byte == '0) ? {r_addr, 1'b0} : r_data[8*MAX_BYTES-1 -: 8];
    assign w_last_byte = (r_byte == r_len) || r_nack;

    // Bus levels for the current state; registered below before the drivers.
    always_comb begin
        w_scl = 1'b1;
        w_sda = 1'b1;
        unique case (r_state)
            StIdle:    begin w_scl = 1'b1; w_sda = 1'b1; end
            StStartI:  begin w_scl = 1'b1; w_sda = 1'b0; end
            StStartII: begin w_scl = 1'b0; w_sda = 1'b0; end
            StHoldI:   begin w_scl = 1'b0; w_sda = 1'b0; end
            StBitI, StBitII, StBitIII, StBitIV: begin
                w_scl = (r_state == StBitII) || (r_state == StBitIII);
                w_sda = (r_bit == 4'd8) ? 1'b1 : w_cur_byte[3'd7 - r_bit[2:0]];
            end
            StHoldII:  begin w_scl = 1'b0; w_sda = 1'b0; end
            StStopI:   begin w_scl = 1'b1; w_sda = 1'b0; end
            StStopII:  begin w_scl = 1'b1; w_sda = 1'b1; end
            default:   begin w_scl = 1'b1; w_sda = 1'b1; end
        endcase
    end

    // Request capture, tick-driven FSM and registered bus/status outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= StIdle;
            r_qcnt  <= 2'd0;
            r_bit   <= 4'd0;
            r_byte  <= '0;
            r_len   <= '0;
            r_addr  <= 7'd0;
            r_data  <= '0;
            r_ready <= 1'b1;
            r_done  <= 1'b0;
            r_nack  <= 1'b0;
            r_scl   <= 1'b1;
            r_sda   <= 1'b1;
        end else begin
            r_done <= 1'b0;
            r_scl  <= w_scl;
            r_sda  <= w_sda;

            if (r_ready && i_start) begin
                r_addr  <= i_addr;
                r_data  <= i_data;
                r_len   <= (i_len > LEN_W'(MAX_BYTES)) ? LEN_W'(MAX_BYTES) : i_len;
                r_ready <= 1'b0;
                r_nack  <= 1'b0;
            end

            if (i_div_clk) begin
                unique case (r_state)
                    StIdle: begin
                        r_qcnt <= 2'd0;
                        r_bit  <= 4'd0;
                        r_byte <= '0;
                        // r_ready is still 1 in the acceptance cycle, so this
                        // only fires on a tick strictly after acceptance.
                        if (!r_ready) r_state <= StStartI;
                    end
                    StStartI, StStartII, StHoldI, StHoldII, StStopI, StStopII: begin
                        if (r_qcnt == 2'd3) begin
                            r_qcnt <= 2'd0;
                            unique case (r_state)
                                StStartI:  r_state <= StStartII;
                                StStartII: r_state <= StHoldI;
                                StHoldI:   r_state <= StBitI;
                                StHoldII:  r_state <= StStopI;
                                StStopI:   r_state <= StStopII;
                                default: begin
                                    r_state <= StIdle;
                                    r_done  <= 1'b1;
                                    r_ready <= 1'b1;
                                end
                            endcase
                        end else begin
                            r_qcnt <= r_qcnt + 2'd1;
                        end
                    end
                    StBitI:  r_state <= StBitII;
                    StBitII: r_state <= StBitIII;
                    StBitIII: begin
`ifdef I2C_ACK_CHECK_EN
                        if ((r_bit == 4'd8) && (io_sda == 1'b1)) r_nack <= 1'b1;
`endif
                        r_state <= StBitIV;
                    end
                    StBitIV: begin
                        if (r_bit == 4'd8) begin
                            r_bit <= 4'd0;
                            if (w_last_byte) begin
                                r_state <= StHoldII;
                            end else begin
                                // Expose the next payload byte once a payload
                                // byte (not the address) has been sent.
                                if (r_byte != '0) r_data <= r_data << 8;
                                r_byte  <= r_byte + LEN_W'(1);
                                r_state <= StBitI;
                            end
                        end else begin
                            r_bit   <= r_bit + 4'd1;
                            r_state <= StBitI;
                        end
                    end
                    default: r_state <= StIdle;
                endcase
            end
        end
    end

    assign o_ready = r_ready;
    assign o_done  = r_done;
    assign o_nack  = r_nack;
    assign o_scl   = r_scl ? 1'bz : 1'b0;
    assign io_sda  = r_sda ? 1'bz : 1'b0;

endmodule

// File: tb/tb_i2c_master_wr.sv
// tb_i2c_master_wr: directed + randomized bench. A bus monitor decodes
// START/STOP and bits on SCL rising edges, a slave model ACKs/NACKs per byte,
// and expectations come from the frame rules (bytes, ACK bits, tick totals).
module tb_i2c_master_wr;
    localparam int MB = 4;
    localparam int LW = $clog2(MB + 1);
`ifdef I2C_ACK_CHECK_EN
    localparam bit ACK_EN = 1'b1;
`else
    localparam bit ACK_EN = 1'b0;
`endif

    logic          i_clk = 1'b0;
    logic          i_rst_n = 1'b1;
    logic          i_div_clk = 1'b0;
    logic          i_start = 1'b0;
    logic [6:0]    i_addr = 7'd0;
    logic [LW-1:0] i_len = '0;
    logic [8*MB-1:0] i_data = '0;
    wire           o_ready;
    wire           o_done;
    wire           o_nack;
    wire           w_scl;
    wire           w_sda;
    logic          slave_low = 1'b0;

    assign w_sda = slave_low ? 1'b0 : 1'bz;
    pullup (w_scl);
    pullup (w_sda);

    i2c_master_wr #(.MAX_BYTES(MB)) dut (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_div_clk (i_div_clk),
        .i_start   (i_start),
        .i_addr    (i_addr),
        .i_len     (i_len),
        .i_data    (i_data),
        .o_ready   (o_ready),
        .o_done    (o_done),
        .o_nack    (o_nack),
        .o_scl     (w_scl),
        .io_sda    (w_sda)
    );

    int checks = 0;
    int errors = 0;

    // monitor / slave state
    bit   mon_bits[$];
    int   n_start = 0, n_stop = 0, n_done = 0, n_tick = 0, nbit = 0;
    logic [7:0] nack_mask = 8'h00;
    logic prev_scl = 1'b1, prev_sda = 1'b1, m_scl, m_sda;
    int   tick_cnt = 0;

    always #5 i_clk = ~i_clk;

    // One tick every third clock.
    always @(posedge i_clk) begin
        #1;
        tick_cnt  = (tick_cnt == 2) ? 0 : tick_cnt + 1;
        i_div_clk = (tick_cnt == 0);
    end

    // Bus monitor and slave responder.
    always @(negedge i_clk) begin
        m_scl = w_scl;
        m_sda = w_sda;
        if (prev_scl && m_scl && prev_sda && !m_sda) begin
            n_start++;
            nbit = 0;
        end
        if (prev_scl && m_scl && !prev_sda && m_sda) begin
            n_stop++;
            // SCL rise of the STOP phase is not a data bit.
            if (mon_bits.size() > 0) void'(mon_bits.pop_back());
        end
        if (!prev_scl && m_scl) begin
            mon_bits.push_back(m_sda);
            nbit++;
        end
        if (prev_scl && !m_scl)
            slave_low = (nbit % 9 == 8) ? !nack_mask[nbit / 9] : 1'b0;
        if (o_done) n_done++;
        // Ticks seen by the DUT while busy, up to and including the done tick.
        if (!o_ready && !o_done && i_div_clk) n_tick++;
        prev_scl = m_scl;
        prev_sda = m_sda;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_mon(input logic [7:0] nmask);
        mon_bits.delete();
        n_start   = 0;
        n_stop    = 0;
        n_done    = 0;
        n_tick    = 0;
        nbit      = 0;
        nack_mask = nmask;
    endtask

    task automatic run_txn(input logic [6:0] addr, input int len, input logic [8*MB-1:0] data,
                           input logic [7:0] nmask, input bit pulse_mid, input string tag);
        int elen, nframe, exp_ticks, cyc;
        bit exp_nack;
        logic [8:0] got, want;
        logic [7:0] eb;
        elen     = (len > MB) ? MB : len;
        nframe   = elen + 1;
        exp_nack = 1'b0;
        for (int k = 0; k <= elen; k++) begin
            if (ACK_EN && nmask[k] && !exp_nack) begin
                nframe   = k + 1;
                exp_nack = 1'b1;
            end
        end
        // +1: the tick that leaves IDLE for START_I
        exp_ticks = 4 * (3 + 9 * nframe + 3) + 1;

        clear_mon(nmask);
        @(negedge i_clk);
        i_addr  = addr;
        i_len   = LW'(len);
        i_data  = data;
        i_start = 1'b1;
        @(posedge i_clk);
        #1;
        i_start = 1'b0;
        i_addr  = 7'($urandom);
        i_len   = LW'($urandom);
        i_data  = $urandom;
        chk({tag, ".ready_low"}, o_ready, 1'b0);
        chk({tag, ".nack_clr"}, o_nack, 1'b0);

        cyc = 0;
        while (n_done == 0 && cyc < 4000) begin
            @(negedge i_clk);
            cyc++;
            if (pulse_mid && cyc == 300) begin
                chk({tag, ".mid_busy"}, o_ready, 1'b0);
                i_start = 1'b1;
                i_addr  = ~addr;
                i_len   = LW'(1);
            end
            if (pulse_mid && cyc == 303) i_start = 1'b0;
        end
        chk({tag, ".no_timeout"}, (cyc < 4000), 1'b1);
        repeat (6) @(negedge i_clk);

        chk({tag, ".done_cnt"}, n_done, 1);
        chk({tag, ".ticks"}, n_tick, exp_ticks);
        chk({tag, ".starts"}, n_start, 1);
        chk({tag, ".stops"}, n_stop, 1);
        chk({tag, ".nbits"}, mon_bits.size(), 9 * nframe);
        chk({tag, ".nack"}, o_nack, exp_nack);
        chk({tag, ".ready"}, o_ready, 1'b1);
        for (int k = 0; k < nframe; k++) begin
            if (mon_bits.size() >= 9 * (k + 1)) begin
                eb   = (k == 0) ? {addr, 1'b0} : 8'(data >> (8 * (MB - k)));
                want = {eb, nmask[k]};
                got  = '0;
                for (int b = 0; b < 9; b++) got = {got[7:0], mon_bits[9 * k + b]};
                chk($sformatf("%s.byte%0d", tag, k), got, want);
            end
        end
    endtask

    initial begin
        int cyc;
        #2 i_rst_n = 1'b0;
        repeat (3) @(negedge i_clk);
        chk("rst.ready", o_ready, 1'b1);
        chk("rst.done", o_done, 1'b0);
        chk("rst.nack", o_nack, 1'b0);
        chk("rst.scl", w_scl, 1'b1);
        chk("rst.sda", w_sda, 1'b1);
        i_rst_n = 1'b1;
        repeat (5) @(negedge i_clk);

        run_txn(7'h1A, 2, 32'hA53C_0000, 8'h00, 1'b1, "len2");
        run_txn(7'h50, 0, $urandom, 8'h00, 1'b0, "probe");
        run_txn(7'h2B, 4, 32'hDEAD_BEEF, 8'h00, 1'b0, "len4");
        run_txn(7'h2B, 7, 32'h0123_4567, 8'h00, 1'b0, "len7");
        run_txn(7'h3C, 3, 32'h1122_3344, 8'h01, 1'b0, "nack_addr");
        repeat (20) @(negedge i_clk);
        chk("nack_hold", o_nack, ACK_EN);

        for (int t = 0; t < 12; t++) begin
            logic [7:0] nm;
            nm = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h00;
            run_txn(7'($urandom), $urandom_range(0, 7), $urandom, nm, 1'b0,
                    $sformatf("rnd%0d", t));
        end

        // Reset during the third bit of payload byte 1 (that bit is 0).
        clear_mon(8'h00);
        @(negedge i_clk);
        i_addr  = 7'h22;
        i_len   = LW'(2);
        i_data  = 32'h1F00_0000;
        i_start = 1'b1;
        @(posedge i_clk);
        #1 i_start = 1'b0;
        cyc = 0;
        while (mon_bits.size() < 11 && cyc < 4000) begin
            @(negedge i_clk);
            cyc++;
        end
        chk("rstmid.reach", (cyc < 4000), 1'b1);
        cyc = 0;
        while (w_scl !== 1'b0 && cyc < 100) begin
            @(negedge i_clk);
            cyc++;
        end
        chk("rstmid.pre_scl", w_scl, 1'b0);
        chk("rstmid.pre_sda", w_sda, 1'b0);
        #2 i_rst_n = 1'b0;
        #1;
        chk("rstmid.scl", w_scl, 1'b1);
        chk("rstmid.sda", w_sda, 1'b1);
        chk("rstmid.ready", o_ready, 1'b1);
        repeat (3) @(negedge i_clk);
        i_rst_n = 1'b1;
        repeat (40) @(negedge i_clk);
        chk("rstmid.no_done", n_done, 0);
        chk("rstmid.stops", n_stop, 0);

        run_txn(7'h5A, 1, 32'hC300_0000, 8'h00, 1'b0, "after_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
